bram_initiator: RTL and testbench

//   Initiator side of the 32-bit BRAM port (MEN/MADDR/MDIN/MWE/MDOUT, 1-cycle read latency).

---
 rtl/bram_initiator.sv | 181 ++++++++++++++++++
 tb/tb_bram_initiator.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_initiator.sv
// bram_initiator
//   Initiator side of a 32-bit synchronous BRAM port (1-cycle read latency).
//   Accepts a valid/ready command stream, issues each legal command to the
//   memory, and returns exactly one response per command, in command order.
//   Misaligned or out-of-range commands are answered locally with ERROR=1
//   and are never driven onto the memory port.
//
// Ports
//   MCLK, MRESET                 clock (posedge) and async active-high reset
//   CMD_VALID/READY              command handshake
//   CMD_WRITE/ADDR/WDATA/WSTRB   command payload (byte address, byte enables)
//   RSP_VALID/READY              response handshake
//   RSP_RDATA/WRITE/ERROR        response payload from the FIFO head
//   MEN/MADDR/MDIN/MWE           registered memory request
//   MDOUT                        memory read data, valid the cycle after MEN
module bram_initiator #(
  parameter int MEM_DEPTH = 1024 * 1024,
  parameter int RSP_DEPTH = 4,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  MCLK,
  input  logic                  MRESET,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic                  CMD_WRITE,
  input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic [31:0]           CMD_WDATA,
  input  logic [3:0]            CMD_WSTRB,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [31:0]           RSP_RDATA,
  output logic                  RSP_WRITE,
  output logic                  RSP_ERROR,
  output logic                  MEN,
  output logic [ADDR_WIDTH-1:0] MADDR,
  output logic [31:0]           MDIN,
  output logic [3:0]            MWE,
  input  logic [31:0]           MDOUT
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  // issue stage (S1)
  logic                  s1_vld_q, s1_vld_d;
  logic                  s1_write_q, s1_write_d;
  logic                  s1_err_q, s1_err_d;
  logic                  men_q, men_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic [31:0]           mdin_q, mdin_d;
  logic [3:0]            mwe_q, mwe_d;

  // capture stage (S2)
  logic                  s2_vld_q, s2_vld_d;
  logic                  s2_write_q, s2_write_d;
  logic                  s2_err_q, s2_err_d;

  // response FIFO
  logic [31:0]           fifo_rdata_q [RSP_DEPTH];
  logic                  fifo_write_q [RSP_DEPTH];
  logic                  fifo_err_q   [RSP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      fifo_count_q, fifo_count_d;

  logic                  accept;
  logic                  cmd_err;
  logic                  push;
  logic                  pop;
  logic [31:0]           cap_rdata;
  logic [7:0]            credits_used;

  // Credits are reserved at accept for every command still in S1/S2 or
  // queued, so the FIFO can never overflow. Only registered state is used:
  // a pop in this cycle frees its slot for the next cycle.
  always_comb begin
    credits_used = 8'(fifo_count_q) + 8'(s1_vld_q) + 8'(s2_vld_q);
    CMD_READY    = !MRESET && (credits_used < 8'(RSP_DEPTH));
  end

  always_comb begin
    accept  = CMD_VALID && CMD_READY;
    cmd_err = (CMD_ADDR[1:0] != 2'b00) ||
              (32'(CMD_ADDR) > 32'(MEM_DEPTH - 4));

    // accept -> S1
    s1_vld_d   = accept;
    s1_write_d = accept ? CMD_WRITE : s1_write_q;
    s1_err_d   = accept ? cmd_err   : s1_err_q;
    men_d      = accept && !cmd_err;
    mwe_d      = (accept && !cmd_err && CMD_WRITE) ? CMD_WSTRB : 4'b0000;
    // Address/data hold when nothing legal is issued, so a rejected
    // address never appears on the memory port.
    maddr_d    = maddr_q;
    mdin_d     = mdin_q;
    if (accept && !cmd_err) begin
      maddr_d = CMD_ADDR;
      mdin_d  = CMD_WDATA;
    end

    // S1 -> S2
    s2_vld_d   = s1_vld_q;
    s2_write_d = s1_write_q;
    s2_err_d   = s1_err_q;

    // S2 -> FIFO
    cap_rdata = (s2_vld_q && !s2_write_q && !s2_err_q) ? MDOUT : 32'h0;
    push      = s2_vld_q;
    pop       = (fifo_count_q != '0) && RSP_READY;

    wr_ptr_d = wr_ptr_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    fifo_count_d = fifo_count_q;
    if (push && !pop) begin
      fifo_count_d = fifo_count_q + 1'b1;
    end else if (!push && pop) begin
      fifo_count_d = fifo_count_q - 1'b1;
    end
  end

  always_ff @(posedge MCLK or posedge MRESET) begin
    if (MRESET) begin
      s1_vld_q     <= 1'b0;
      s1_write_q   <= 1'b0;
      s1_err_q     <= 1'b0;
      men_q        <= 1'b0;
      maddr_q      <= '0;
      mdin_q       <= 32'h0;
      mwe_q        <= 4'b0000;
      s2_vld_q     <= 1'b0;
      s2_write_q   <= 1'b0;
      s2_err_q     <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      s1_vld_q     <= s1_vld_d;
      s1_write_q   <= s1_write_d;
      s1_err_q     <= s1_err_d;
      men_q        <= men_d;
      maddr_q      <= maddr_d;
      mdin_q       <= mdin_d;
      mwe_q        <= mwe_d;
      s2_vld_q     <= s2_vld_d;
      s2_write_q   <= s2_write_d;
      s2_err_q     <= s2_err_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
    end
  end

  // FIFO storage carries no reset; emptiness is tracked by fifo_count_q.
  always_ff @(posedge MCLK) begin
    if (push) begin
      fifo_rdata_q[wr_ptr_q] <= cap_rdata;
      fifo_write_q[wr_ptr_q] <= s2_write_q;
      fifo_err_q[wr_ptr_q]   <= s2_err_q;
    end
  end

  // FIFO head -> response port, forced to 0 when empty
  always_comb begin
    RSP_VALID = (fifo_count_q != '0);
    RSP_RDATA = RSP_VALID ? fifo_rdata_q[rd_ptr_q] : 32'h0;
    RSP_WRITE = RSP_VALID ? fifo_write_q[rd_ptr_q] : 1'b0;
    RSP_ERROR = RSP_VALID ? fifo_err_q[rd_ptr_q]   : 1'b0;
  end

  assign MEN   = men_q;
  assign MADDR = maddr_q;
  assign MDIN  = mdin_q;
  assign MWE   = mwe_q;

endmodule

// File: tb/tb_bram_initiator.sv
// tb_bram_initiator
//   Directed bench for bram_initiator with a behavioural 1-cycle-latency BRAM.
//   MEM_DEPTH is 1000 bytes so that the address MEM_DEPTH itself fits in
//   CMD_ADDR and the upper range boundary can be exercised.
module tb_bram_initiator;

  localparam int MEM_DEPTH = 1000;
  localparam int RSP_DEPTH = 4;
  localparam int AW        = $clog2(MEM_DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_write, rsp_error;
  logic [31:0]   rsp_rdata;
  logic          men;
  logic [AW-1:0] maddr;
  logic [31:0]   mdin, mdout;
  logic [3:0]    mwe;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] mem [256];
  logic [33:0] got_q[$];
  logic [33:0] exp_q[$];
  int          got_cyc[$];

  bram_initiator #(.MEM_DEPTH(MEM_DEPTH), .RSP_DEPTH(RSP_DEPTH)) dut (
    .MCLK(clk), .MRESET(rst),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_WRITE(cmd_write),
    .CMD_ADDR(cmd_addr), .CMD_WDATA(cmd_wdata), .CMD_WSTRB(cmd_wstrb),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_RDATA(rsp_rdata),
    .RSP_WRITE(rsp_write), .RSP_ERROR(rsp_error),
    .MEN(men), .MADDR(maddr), .MDIN(mdin), .MWE(mwe), .MDOUT(mdout)
  );

  always #5 clk = ~clk;

  // Initial memory image: word 4 (0x10) = 0xCAFEF00D, word 8 (0x20) = 0.
  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hCAFE_F00D;
    if (i == 8) return 32'h0;
    return 32'hA500_0000 | 32'(i);
  endfunction

  // Memory contents after the T2 write (bytes 0 and 2 of 0x11223344).
  function automatic logic [31:0] cur_word(input int i);
    if (i == 8) return 32'h0022_0044;
    return init_word(i);
  endfunction

  // Behavioural BRAM: byte-lane writes, registered read-before-write data.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (men) begin
      for (int b = 0; b < 4; b++) begin
        if (mwe[b]) mem[maddr[9:2]][8*b +: 8] <= mdin[8*b +: 8];
      end
      mdout <= mem[maddr[9:2]];
    end
  end

  // Responses are recorded mid-cycle; the handshake completes at the next edge.
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      got_q.push_back({rsp_write, rsp_error, rsp_rdata});
      got_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command and return one cycle after it is accepted (cycle E+1).
  task automatic send(input string tag, input logic w, input logic [AW-1:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    if (!cmd_ready) begin
      check({tag, "_ready_timeout"}, 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic expect_rsp(input logic w, input logic e, input logic [31:0] d);
    exp_q.push_back({w, e, d});
  endtask

  // Wait (bounded) for n responses and compare them in order.
  task automatic drain(input string tag, input int n);
    int w = 0;
    logic [33:0] g, x;
    while (got_q.size() < n && w < 200) begin
      tick();
      w++;
    end
    check({tag, "_count"}, 64'(got_q.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (got_q.size() == 0 || exp_q.size() == 0) break;
      g = got_q.pop_front();
      x = exp_q.pop_front();
      check($sformatf("%s_rsp%0d", tag, i), 64'(g), 64'(x));
    end
    exp_q.delete();
  endtask

  initial begin
    int acc, idx, w, rdy_cnt;
    for (int i = 0; i < 256; i++) mem[i] = init_word(i);
    mdout = 32'h0;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
    rsp_ready = 1'b0;
    tick(); tick();
    check("rst_cmd_ready", 64'(cmd_ready), 0);
    check("rst_men", 64'(men), 0);
    check("rst_rsp_valid", 64'(rsp_valid), 0);
    check("rst_outs", 64'({maddr, mdin, mwe, rsp_rdata}), 0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    tick();

    // T1: read 0x10, exact timing
    check("t1_ready", 64'(cmd_ready), 1);
    send("t1", 1'b0, 10'h010, 32'h0, 4'h0);
    check("t1_men_e1", 64'(men), 1);
    check("t1_maddr_e1", 64'(maddr), 64'h10);
    check("t1_mwe_e1", 64'(mwe), 0);
    check("t1_rv_e1", 64'(rsp_valid), 0);
    tick();
    check("t1_men_e2", 64'(men), 0);
    check("t1_maddr_hold", 64'(maddr), 64'h10);
    check("t1_rv_e2", 64'(rsp_valid), 0);
    tick();
    check("t1_rv_e3", 64'(rsp_valid), 1);
    check("t1_rsp_e3", 64'({rsp_write, rsp_error, rsp_rdata}), 64'h0_CAFE_F00D);
    tick();
    got_q.delete();

    // T2: partial write then read back
    send("t2w", 1'b1, 10'h020, 32'h1122_3344, 4'b0101);
    check("t2_men", 64'(men), 1);
    check("t2_mwe", 64'(mwe), 64'b0101);
    check("t2_mdin", 64'(mdin), 64'h1122_3344);
    expect_rsp(1'b1, 1'b0, 32'h0);
    send("t2r", 1'b0, 10'h020, 32'h0, 4'h0);
    expect_rsp(1'b0, 1'b0, 32'h0022_0044);
    drain("t2", 2);

    // T3: misaligned, MEM_DEPTH, last legal word, out-of-range write
    send("t3a", 1'b0, 10'h022, 32'h0, 4'h0);
    check("t3_men_misaligned", 64'(men), 0);
    expect_rsp(1'b0, 1'b1, 32'h0);
    send("t3b", 1'b0, 10'(MEM_DEPTH), 32'h0, 4'h0);
    check("t3_men_depth", 64'(men), 0);
    expect_rsp(1'b0, 1'b1, 32'h0);
    send("t3c", 1'b0, 10'(MEM_DEPTH - 4), 32'h0, 4'h0);
    check("t3_men_last", 64'(men), 1);
    expect_rsp(1'b0, 1'b0, init_word(249));
    send("t3d", 1'b1, 10'h3FC, 32'hFFFF_FFFF, 4'hF);
    check("t3_men_wr_oor", 64'(men), 0);
    check("t3_mwe_wr_oor", 64'(mwe), 0);
    expect_rsp(1'b1, 1'b1, 32'h0);
    drain("t3", 4);

    // T4: backpressure, credits limit acceptance to RSP_DEPTH
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0;
    acc = 0; idx = 0;
    for (int c = 0; c < 10; c++) begin
      cmd_addr = 10'(idx * 4);
      if (cmd_ready) begin
        acc++;
        expect_rsp(1'b0, 1'b0, cur_word(idx));
        idx++;
      end
      tick();
    end
    check("t4_accepted", 64'(acc), 64'(RSP_DEPTH));
    check("t4_ready_low", 64'(cmd_ready), 0);
    check("t4_head", 64'({rsp_valid, rsp_rdata}), {31'h0, 1'b1, init_word(0)});
    tick();
    check("t4_head_stable", 64'({rsp_valid, rsp_rdata}), {31'h0, 1'b1, init_word(0)});
    rsp_ready = 1'b1;
    w = 0;
    while (idx < 8 && w < 50) begin
      cmd_addr = 10'(idx * 4);
      if (cmd_ready) begin
        expect_rsp(1'b0, 1'b0, cur_word(idx));
        idx++;
      end
      tick();
      w++;
    end
    cmd_valid = 1'b0;
    check("t4_all_sent", 64'(idx), 8);
    drain("t4", 8);

    // T5: 16 back-to-back reads at full rate
    got_cyc.delete();
    cmd_valid = 1'b1; cmd_write = 1'b0;
    rdy_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      cmd_addr = 10'(i * 4);
      if (cmd_ready) rdy_cnt++;
      expect_rsp(1'b0, 1'b0, cur_word(i));
      tick();
    end
    cmd_valid = 1'b0;
    check("t5_ready_every_cycle", 64'(rdy_cnt), 16);
    w = 0;
    while (got_cyc.size() < 16 && w < 100) begin
      tick();
      w++;
    end
    check("t5_rsp_span", (got_cyc.size() == 16) ? 64'(got_cyc[15] - got_cyc[0]) : 64'hFFFF, 15);
    drain("t5", 16);

    // T6: reset with 2 in flight and 2 queued
    rsp_ready = 1'b0;
    send("t6a", 1'b0, 10'h000, 32'h0, 4'h0);
    send("t6b", 1'b0, 10'h004, 32'h0, 4'h0);
    send("t6c", 1'b0, 10'h008, 32'h0, 4'h0);
    cmd_valid = 1'b1; cmd_addr = 10'h00C;
    check("t6_ready_4th", 64'(cmd_ready), 1);
    tick();
    cmd_valid = 1'b0;
    check("t6_men_before", 64'(men), 1);
    check("t6_rv_before", 64'(rsp_valid), 1);
    rst = 1'b1;
    #1;
    check("t6_rst_ready", 64'(cmd_ready), 0);
    check("t6_rst_men_mwe", 64'({men, mwe}), 0);
    check("t6_rst_rsp", 64'({rsp_valid, rsp_write, rsp_error, rsp_rdata}), 0);
    check("t6_rst_maddr_mdin", 64'({maddr, mdin}), 0);
    tick(); tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("t6_no_stale", 64'(got_q.size()), 0);
    got_q.delete();
    send("t6r", 1'b0, 10'h010, 32'h0, 4'h0);
    expect_rsp(1'b0, 1'b0, 32'hCAFE_F00D);
    drain("t6", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
